// File: rtl/sa_seq_ctrl_pkg.sv
// Shared configuration and state encoding for the systolic-array tile-pass sequencer.
// Holds default array geometry, the one-hot phase encoding and the per-phase enable decode.
package sa_seq_ctrl_pkg;

  localparam int unsigned ArrayWidthDef  = 16;
  localparam int unsigned ArrayHeightDef = 16;
  localparam int unsigned DspDelayDef    = 1;

  typedef enum logic [6:0] {
    StIdle    = 7'b000_0001,
    StLoadW   = 7'b000_0010,
    StLoadIn  = 7'b000_0100,
    StCompute = 7'b000_1000,
    StDrain   = 7'b001_0000,
    StUnload  = 7'b010_0000,
    StDone    = 7'b100_0000
  } state_e;

  typedef struct packed {
    logic wb_load;
    logic wb_out;
    logic write_w;
    logic ib_load;
    logic ib_out;
    logic ob_load;
    logic unload;
  } ctrl_t;

  // Enables that depend on the phase alone; counter-dependent outputs are decoded in the top.
  function automatic ctrl_t phase_ctrl(state_e st);
    ctrl_t c;
    c = '0;
    unique case (st)
      StLoadW: c.wb_load = 1'b1;
      StLoadIn: begin
        c.ib_load = 1'b1;
        c.write_w = 1'b1;
        c.wb_out  = 1'b1;
      end
      StCompute: c.ib_out = 1'b1;
      StDrain: begin
        c.ib_out  = 1'b1;
        c.ob_load = 1'b1;
      end
      StUnload: begin
        c.ib_out = 1'b1;
        c.unload = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sa_seq_ctrl.sv
// Phase sequencer for one systolic-array tile pass: load weights, load activations,
// compute, drain and unload, driving every buffer enable of the array top.
module sa_seq_ctrl
  import sa_seq_ctrl_pkg::*;
#(
  parameter int unsigned ARRAYWIDTH  = ArrayWidthDef,
  parameter int unsigned ARRAYHEIGHT = ArrayHeightDef,
  parameter int unsigned DSP_DELAY   = DspDelayDef,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ADDR_W      = $clog2(2 * ARRAYHEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] src_addr,
  output logic              weight_buffer_load_en,
  output logic              weight_buffer_out_en,
  output logic              write_weight_en,
  output logic              input_buffer_load_en,
  output logic              input_buffer_out_en,
  output logic              output_buffer_load_en,
  output logic              output_buffer_out_en,
  output logic [ADDR_W-1:0] out_row,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LoadLen    = ARRAYHEIGHT;
  localparam int unsigned ComputeLen = DSP_DELAY * ARRAYWIDTH;
  localparam int unsigned DrainLen   = DSP_DELAY * (ARRAYHEIGHT - 1) + ARRAYHEIGHT;
  localparam int unsigned UnloadLen  = ARRAYHEIGHT;
  localparam int unsigned MaxLen     = (DrainLen > ComputeLen) ? DrainLen : ComputeLen;

  if (longint'(MaxLen) > (longint'(1) << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too narrow for the longest phase");
  end
  if (longint'(2 * ARRAYHEIGHT) > (longint'(1) << ADDR_W)) begin : g_addr_w_check
    $error("ADDR_W too narrow for 2*ARRAYHEIGHT source rows");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [ADDR_W-1:0]  src_addr_q, src_addr_d;
  logic [ADDR_W-1:0]  out_row_q, out_row_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next phase and counter; each phase advances on its last count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StLoadW;
            cnt_d   = '0;
          end
        end
        StLoadW: begin
          if (cnt_q == CNT_W'(LoadLen - 1)) begin
            state_d = StLoadIn;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StLoadIn: begin
          if (cnt_q == CNT_W'(LoadLen - 1)) begin
            state_d = StCompute;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StCompute: begin
          if (cnt_q == CNT_W'(ComputeLen - 1)) begin
            state_d = StDrain;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StDrain: begin
          if (cnt_q == CNT_W'(DrainLen - 1)) begin
            state_d = StUnload;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StUnload: begin
          // Only this phase stalls: the row counter moves only when the sink accepts.
          if (out_ready) begin
            if (cnt_q == CNT_W'(UnloadLen - 1)) begin
              state_d = StDone;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        StDone: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they land in registers aligned with the phase.
  always_comb begin
    ctrl_d     = phase_ctrl(state_d);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
    src_addr_d = '0;
    out_row_d  = '0;
    if (state_d == StLoadW) begin
      src_addr_d = ADDR_W'(cnt_d);
    end else if (state_d == StLoadIn) begin
      src_addr_d = ADDR_W'(ARRAYHEIGHT) + ADDR_W'(cnt_d);
    end
    if (state_d == StUnload) begin
      out_row_d = ADDR_W'(cnt_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ctrl_q     <= '0;
      src_addr_q <= '0;
      out_row_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctrl_q     <= ctrl_d;
      src_addr_q <= src_addr_d;
      out_row_q  <= out_row_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign weight_buffer_load_en = ctrl_q.wb_load;
  assign weight_buffer_out_en  = ctrl_q.wb_out;
  assign write_weight_en       = ctrl_q.write_w;
  assign input_buffer_load_en  = ctrl_q.ib_load;
  assign input_buffer_out_en   = ctrl_q.ib_out;
  assign output_buffer_load_en = ctrl_q.ob_load;
  assign output_buffer_out_en  = ctrl_q.unload & out_ready;
  assign src_addr              = src_addr_q;
  assign out_row               = out_row_q;
  assign busy                  = busy_q;
  assign done                  = done_q;

endmodule
